wave_freq_meter: RTL and testbench

- Measures the fundamental frequency of a 10-bit ADC waveform in the 1–100 kHz range.
- The waveform is sampled at 256 kHz. The block counts rising threshold crossings with hysteresis over a fixed gate, then converts the count to kHz.
- Sits between the ADC capture path and the display/measurement controller. It runs entirely in the 50 MHz system domain; samples are qualified by a strobe.

---
 rtl/wave_freq_pkg.sv | 20 ++
 rtl/wave_freq_div.sv | 73 +++++++
 rtl/wave_freq_meter.sv | 151 +++++++++++++++
 tb/tb_wave_freq_meter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/wave_freq_pkg.sv
// Shared constants and state types for the waveform frequency meter.
package wave_freq_pkg;

  localparam int ADC_W          = 10;
  localparam int SAMPLES_PER_MS = 256;

  localparam logic [ADC_W-1:0] MID_RESET = 10'd512;
  localparam logic [ADC_W-1:0] ADC_MAX   = '1;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } cmp_state_e;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/wave_freq_div.sv
// Restoring serial unsigned divider: one quotient bit per clock, done pulses
// W cycles after the start cycle.
module wave_freq_div
  import wave_freq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quotient_o,
  output logic         done_o
);

  localparam int            IT_W    = $clog2(W);
  localparam logic [IT_W-1:0] IT_LAST = IT_W'(W - 1);

  div_state_e      state_q;
  logic [W-1:0]    rem_q;
  logic [W-1:0]    quo_q;
  logic [W-1:0]    dsr_q;
  logic [IT_W-1:0] it_q;
  logic            done_q;

  logic [W:0]   trial;
  logic         fits;
  logic [W-1:0] rem_sub;

  // The dividend shifts out of quo_q's MSB while quotient bits enter at the LSB.
  assign trial   = {rem_q, quo_q[W-1]};
  assign fits    = (trial >= {1'b0, dsr_q});
  assign rem_sub = trial[W-1:0] - dsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      it_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            rem_q   <= '0;
            quo_q   <= dividend_i;
            dsr_q   <= divisor_i;
            it_q    <= '0;
            state_q <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          rem_q <= fits ? rem_sub : trial[W-1:0];
          quo_q <= {quo_q[W-2:0], fits};
          it_q  <= it_q + 1'b1;
          if (it_q == IT_LAST) begin
            state_q <= DIV_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = done_q;

endmodule

// File: rtl/wave_freq_meter.sv
// Waveform frequency meter: counts hysteretic rising crossings over a gate of
// 256*GATE_MS samples and reports round(count/GATE_MS) in kHz.
// Define WAVE_FREQ_ADAPT_EN to re-centre the threshold on each gate's min/max.
module wave_freq_meter
  import wave_freq_pkg::*;
#(
  parameter int GATE_MS = 10,
  parameter int HYST    = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [ADC_W-1:0] ad_data,
  output logic [7:0]       freq,
  output logic             freq_valid
);

  localparam int                 GATE_SAMPLES = SAMPLES_PER_MS * GATE_MS;
  localparam int                 SCNT_W       = $clog2(GATE_SAMPLES);
  localparam logic [SCNT_W-1:0]  GATE_LAST    = SCNT_W'(GATE_SAMPLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
  localparam logic [CNT_W-1:0]   ROUND_ADD    = CNT_W'(GATE_MS / 2);
  localparam logic [CNT_W-1:0]   DIVISOR      = CNT_W'(GATE_MS);
  localparam logic signed [ADC_W:0] HYST_S    = (ADC_W + 1)'(HYST);

  logic [SCNT_W-1:0] scnt_q;
  logic [CNT_W-1:0]  xcnt_q;
  logic [CNT_W-1:0]  xcnt_d;
  cmp_state_e        cmp_q;
  logic [ADC_W-1:0]  mid;
  logic [7:0]        freq_q;
  logic              freq_valid_q;

  logic signed [ADC_W:0] sample_s;
  logic signed [ADC_W:0] mid_s;
  logic                  go_high;
  logic                  go_low;
  logic                  rise;
  logic                  gate_close;
  logic [CNT_W-1:0]      dividend;
  logic [CNT_W-1:0]      quotient;
  logic                  div_done;

  // Signed, one bit wider than the ADC, so mid +/- HYST cannot wrap.
  assign sample_s = signed'({1'b0, ad_data});
  assign mid_s    = signed'({1'b0, mid});
  assign go_high  = (cmp_q == LOW)  && (sample_s >= mid_s + HYST_S);
  assign go_low   = (cmp_q == HIGH) && (sample_s <= mid_s - HYST_S);
  assign rise     = sample_en && go_high;

  assign gate_close = sample_en && (scnt_q == GATE_LAST);
  assign xcnt_d     = (rise && (xcnt_q != CNT_MAX)) ? xcnt_q + 1'b1 : xcnt_q;

  // Round-half-up bias; clamping only matters when the quotient saturates anyway.
  assign dividend = (xcnt_d > CNT_MAX - ROUND_ADD) ? CNT_MAX : xcnt_d + ROUND_ADD;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      cmp_q <= LOW;
    end else if (sample_en) begin
      if (go_high) begin
        cmp_q <= HIGH;
      end else if (go_low) begin
        cmp_q <= LOW;
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      scnt_q <= '0;
      xcnt_q <= '0;
    end else if (sample_en) begin
      if (gate_close) begin
        scnt_q <= '0;
        xcnt_q <= '0;
      end else begin
        scnt_q <= scnt_q + 1'b1;
        xcnt_q <= xcnt_d;
      end
    end
  end

`ifdef WAVE_FREQ_ADAPT_EN
  logic [ADC_W-1:0] mid_q;
  logic [ADC_W-1:0] win_min_q;
  logic [ADC_W-1:0] win_max_q;
  logic [ADC_W-1:0] win_min_d;
  logic [ADC_W-1:0] win_max_d;
  logic [ADC_W:0]   win_span;
  logic [ADC_W:0]   win_sum;

  // The closing sample belongs to the window it closes.
  assign win_min_d = (ad_data < win_min_q) ? ad_data : win_min_q;
  assign win_max_d = (ad_data > win_max_q) ? ad_data : win_max_q;
  assign win_span  = {1'b0, win_max_d} - {1'b0, win_min_d};
  assign win_sum   = {1'b0, win_max_d} + {1'b0, win_min_d};

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      mid_q     <= MID_RESET;
      win_min_q <= ADC_MAX;
      win_max_q <= '0;
    end else if (sample_en) begin
      if (gate_close) begin
        win_min_q <= ADC_MAX;
        win_max_q <= '0;
        if (win_span >= (ADC_W + 1)'(2 * HYST)) begin
          mid_q <= win_sum[ADC_W:1];
        end
      end else begin
        win_min_q <= win_min_d;
        win_max_q <= win_max_d;
      end
    end
  end

  assign mid = mid_q;
`else
  assign mid = MID_RESET;
`endif

  wave_freq_div #(
    .W (CNT_W)
  ) u_div (
    .clk_i      (clk_50m),
    .rst_i      (rst),
    .start_i    (gate_close),
    .dividend_i (dividend),
    .divisor_i  (DIVISOR),
    .quotient_o (quotient),
    .done_o     (div_done)
  );

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
    end else begin
      freq_valid_q <= div_done;
      if (div_done) begin
        freq_q <= (quotient[CNT_W-1:8] != '0) ? 8'hFF : quotient[7:0];
      end
    end
  end

  assign freq       = freq_q;
  assign freq_valid = freq_valid_q;

endmodule

// File: tb/tb_wave_freq_meter.sv
// Directed bench for wave_freq_meter: whole gates of patterned samples, each
// gate's expected kHz queued at its closing sample and matched on freq_valid.
module tb_wave_freq_meter;

  localparam int GATE_N = 2560;
  localparam int LAT    = 17;

  localparam int P_SQ1K  = 0;
  localparam int P_64K   = 1;
  localparam int P_128K  = 2;
  localparam int P_C15   = 3;
  localparam int P_C14   = 4;
  localparam int P_RST5  = 5;
  localparam int P_POST  = 6;
  localparam int P_CONST = 7;
  localparam int P_ALT   = 8;
  localparam int P_AD    = 9;

  logic       clk_50m = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [9:0] ad_data;
  logic [7:0] freq;
  logic       freq_valid;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  logic [7:0]  exp_q[$];
  int unsigned lat_q[$];
  logic [7:0]  held_freq = 8'd0;

  wave_freq_meter #(
    .GATE_MS (10),
    .HYST    (16),
    .CNT_W   (16)
  ) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .sample_en  (sample_en),
    .ad_data    (ad_data),
    .freq       (freq),
    .freq_valid (freq_valid)
  );

  // Clock / cycle counter
  always #10 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every freq_valid must match the oldest queued gate result.
  always @(negedge clk_50m) begin
    if (!rst && freq_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        logic [7:0]  e;
        int unsigned c;
        e = exp_q.pop_front();
        c = lat_q.pop_front();
        check("freq", freq, e);
        check("latency", cyc - c, LAT);
        held_freq = e;
      end
    end
  end

  function automatic logic [9:0] pat_val(input int p, input int i);
    logic [9:0] v;
    case (p)
      P_SQ1K:  v = (((i / 128) % 2) == 0) ? 10'd0 : 10'd1023;
      P_64K:   v = ((i % 4) < 2) ? 10'd0 : 10'd1023;
      P_128K:  v = ((i % 2) == 1) ? 10'd1023 : 10'd0;
      P_C15:   v = (((i < 28) && (i % 2 == 1)) || (i == GATE_N - 1)) ? 10'd1023 : 10'd0;
      P_C14:   v = ((i < 28) && (i % 2 == 1)) ? 10'd1023 : 10'd0;
      P_RST5:  v = ((i < 10) && (i % 2 == 1)) ? 10'd1023 : 10'd0;
      P_POST:  v = ((i < 60) && (i % 2 == 1)) ? 10'd1023 : 10'd0;
      P_CONST: v = 10'd512;
      P_ALT:   v = ((i % 2) == 1) ? 10'd519 : 10'd505;
      P_AD:    v = (((i / 13) % 2) == 0) ? 10'd700 : 10'd600;
      default: v = 10'd0;
    endcase
    return v;
  endfunction

  // Driver: one strobe then one idle cycle carrying junk data.
  task automatic send(input logic [9:0] v, input bit close, input logic [7:0] e);
    @(negedge clk_50m);
    sample_en = 1'b1;
    ad_data   = v;
    if (close) begin
      exp_q.push_back(e);
      lat_q.push_back(cyc + 1);
    end
    @(negedge clk_50m);
    sample_en = 1'b0;
    ad_data   = 10'($urandom_range(0, 1023));
  endtask

  task automatic run_gate(input int p, input logic [7:0] e, input string tag);
    for (int i = 0; i < GATE_N; i++) begin
      send(pat_val(p, i), i == GATE_N - 1, e);
      if (i == GATE_N / 2) check({tag, "_hold"}, freq, held_freq);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_50m);
    rst       = 1'b1;
    sample_en = 1'b0;
    repeat (2) @(negedge clk_50m);
    check({tag, "_freq"}, freq, 0);
    check({tag, "_valid"}, freq_valid, 0);
    rst       = 1'b0;
    held_freq = 8'd0;
  endtask

  initial begin
    rst       = 1'b1;
    sample_en = 1'b0;
    ad_data   = 10'd0;
    do_reset("rst");

    run_gate(P_SQ1K, 8'd1, "sq1k_a");
    run_gate(P_SQ1K, 8'd1, "sq1k_b");
    run_gate(P_64K, 8'd64, "sq64k");
    run_gate(P_128K, 8'd128, "sq128k");
    run_gate(P_C15, 8'd2, "cnt15");
    run_gate(P_C14, 8'd1, "cnt14");

    for (int i = 0; i < 100; i++) send(pat_val(P_RST5, i), 1'b0, 8'd0);
    do_reset("midrst");

    run_gate(P_POST, 8'd3, "post_rst");
    run_gate(P_CONST, 8'd0, "const");
    run_gate(P_ALT, 8'd0, "in_hyst");
    run_gate(P_AD, 8'd0, "ad_first");
`ifdef WAVE_FREQ_ADAPT_EN
    run_gate(P_AD, 8'd10, "ad_second");
`else
    run_gate(P_AD, 8'd0, "ad_second");
`endif

    for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk_50m);
    check("pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
